// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, FSM
// states and the default operand width. Also imported by the EX-stage decoder
// and the result-mux select logic.
package mult_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } state_e;

  // Op[0] selects signed operation, Op[1] selects divide.
  function automatic logic op_is_signed(logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate. y = en ? (~a + cin) : a.
// cin/cout let two instances form a double-width negate: the low half uses
// cin=1 and its carry-out feeds the high half's cin.
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0] sum;

  // Invert-and-increment, bypassed when not enabled.
  always_comb begin
    sum  = {1'b0, ~a} + {{WIDTH{1'b0}}, cin};
    y    = en ? sum[WIDTH-1:0] : a;
    cout = sum[WIDTH];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) writing HI/LO.
// Works on operand magnitudes one bit per cycle (shift-add multiply, restoring
// divide), then applies the sign fix-up in a single FIX cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  state_e             state_q;
  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q;
  logic               dz_q;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;       // {hi, lo}: product, or {rem, quo}
  logic [CntW-1:0]    cnt_q;
  logic               busy_q, done_q, divzero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand magnitudes, taken only for signed ops with a negative operand.
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             unused_a_cout, unused_b_cout, unused_hi_cout;

  assign neg_a = op_is_signed(Op) & A[WIDTH-1];
  assign neg_b = op_is_signed(Op) & B[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
    .en   (neg_a),
    .cin  (1'b1),
    .a    (A),
    .y    (a_abs),
    .cout (unused_a_cout)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
    .en   (neg_b),
    .cin  (1'b1),
    .a    (B),
    .y    (b_abs),
    .cout (unused_b_cout)
  );

  // Result fix-up. For multiply the two instances chain into a 2W negate;
  // for divide the quotient (low) and remainder (high) negate independently.
  logic             is_div_q, neg_lo, neg_hi, lo_cout, hi_cin;
  logic [WIDTH-1:0] lo_fix, hi_fix;

  assign is_div_q = op_is_div(op_q);
  assign neg_lo   = sign_a_q ^ sign_b_q;
  assign neg_hi   = is_div_q ? sign_a_q : neg_lo;
  assign hi_cin   = is_div_q ? 1'b1 : lo_cout;

  mdu_negate #(.WIDTH(WIDTH)) u_fix_lo (
    .en   (neg_lo),
    .cin  (1'b1),
    .a    (acc_q[WIDTH-1:0]),
    .y    (lo_fix),
    .cout (lo_cout)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_hi (
    .en   (neg_hi),
    .cin  (hi_cin),
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (hi_fix),
    .cout (unused_hi_cout)
  );

  // One iteration of each datapath; the FSM picks the one matching op_q.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Trial subtract on the shifted remainder; sign bit set means it did not fit.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Control FSM with registered Busy/Done/DivZero and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (Start) begin
            op_q      <= Op;
            sign_a_q  <= neg_a;
            sign_b_q  <= neg_b;
            busy_q    <= 1'b1;
            divzero_q <= 1'b0;
            cnt_q     <= CntInit;
            if (op_is_div(Op)) begin
              // Divide by zero parks raw A in the high half for the FIX write.
              dz_q    <= (B == '0);
              opnd_q  <= b_abs;
              acc_q   <= {((B == '0) ? A : {WIDTH{1'b0}}), a_abs};
              state_q <= (B == '0) ? StFix : StCalc;
            end else begin
              dz_q    <= 1'b0;
              opnd_q  <= a_abs;
              acc_q   <= {{WIDTH{1'b0}}, b_abs};
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          if (dz_q) begin
            hi_q      <= acc_q[2*WIDTH-1:WIDTH];
            lo_q      <= {WIDTH{1'b1}};
            divzero_q <= 1'b1;
          end else begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
